// File: rtl/sliding_window_pkg.sv
// Shared definitions for the sliding-window stream generator:
// coordinate width, controller states and the frame geometry check.
package sliding_window_pkg;

    localparam int XRES_WIDTH = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A frame is usable only if a full K x K window fits and the line fits the buffers.
    function automatic logic geometry_ok(
        input logic [XRES_WIDTH-1:0] xres,
        input logic [XRES_WIDTH-1:0] yres,
        input logic [XRES_WIDTH-1:0] k,
        input logic [XRES_WIDTH-1:0] max_xres
    );
        return (xres >= k) && (xres <= max_xres) && (yres >= k);
    endfunction

endpackage

// File: rtl/sliding_window_stream_line_buffer.sv
// One raster line of pixels, addressed by column.
// Combinational read, synchronous write; a read and write to the same column
// in one cycle returns the old contents. Storage is intentionally not reset.
module line_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Column write on every accepted pixel.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sliding_window_stream.sv
// Streaming K x K multi-channel window generator.
// Raster pixels in over valid/ready, fully populated windows out with their
// top-left coordinate and a last-window marker.
// Optional stride-2 decimation: define SLIDING_WINDOW_STRIDE2_EN.
//
// state | meaning
// IDLE  | waiting for an SOF beat with usable geometry; other beats dropped
// RUN   | frame in progress; each accepted beat advances the raster position
module sliding_window_stream
    import sliding_window_pkg::*;
#(
    parameter int K        = 3,
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 16,
    parameter int MAX_XRES = 64
) (
    input  logic                                       clock,
    input  logic                                       clock_areset,
    input  logic [XRES_WIDTH-1:0]                      xres,
    input  logic [XRES_WIDTH-1:0]                      yres,
`ifdef SLIDING_WINDOW_STRIDE2_EN
    input  logic                                       stride2,
`endif
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       in_sof,
    input  logic [CHANNELS-1:0][WIDTH-1:0]             in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [CHANNELS-1:0][K*K-1:0][WIDTH-1:0]    window,
    output logic [XRES_WIDTH-1:0]                      out_x,
    output logic [XRES_WIDTH-1:0]                      out_y,
    output logic                                       out_last,
    output logic                                       frame_error
);

    localparam int ADDR_WIDTH = (MAX_XRES > 1) ? $clog2(MAX_XRES) : 1;
    localparam logic [XRES_WIDTH-1:0] K_V   = XRES_WIDTH'(K);
    localparam logic [XRES_WIDTH-1:0] K_M1  = XRES_WIDTH'(K - 1);
    localparam logic [XRES_WIDTH-1:0] MAX_V = XRES_WIDTH'(MAX_XRES);

    typedef logic [CHANNELS-1:0][WIDTH-1:0]          pixel_t;
    typedef logic [CHANNELS-1:0][K*K-1:0][WIDTH-1:0] window_t;

    state_t                  state_q, state_d;
    logic [XRES_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [XRES_WIDTH-1:0]   xres_q, yres_q;
    logic [XRES_WIDTH-1:0]   beat_x, beat_y, eff_xres, eff_yres, last_x, last_y;
    logic                    accept, sof_beat, geom_ok_in, start, process;
    logic                    stride_eff, emit, last_win, end_of_line;
    window_t                 win_q, win_d;
    pixel_t                  lb_rd [K-1];
    pixel_t                  col_d [K];

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign sof_beat   = accept && in_sof;
    assign geom_ok_in = geometry_ok(xres, yres, K_V, MAX_V);
    assign start      = sof_beat && geom_ok_in;
    assign process    = start || (accept && !in_sof && state_q == RUN);

`ifdef SLIDING_WINDOW_STRIDE2_EN
    logic stride_q;
    assign stride_eff = start ? stride2 : stride_q;
`else
    assign stride_eff = 1'b0;
`endif

    // Raster position of the current beat, next-state and emission decision.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        beat_x      = start ? '0 : x_q;
        beat_y      = start ? '0 : y_q;
        eff_xres    = start ? xres : xres_q;
        eff_yres    = start ? yres : yres_q;
        end_of_line = (beat_x == eff_xres - 10'd1);
        last_x      = eff_xres - 10'd1;
        last_y      = eff_yres - 10'd1;
        if (stride_eff) begin
            // With odd (res - K) the final pixel has the wrong parity; step back one.
            if (eff_xres[0] != K_V[0]) last_x = eff_xres - 10'd2;
            if (eff_yres[0] != K_V[0]) last_y = eff_yres - 10'd2;
        end
        emit = process && (beat_x >= K_M1) && (beat_y >= K_M1) &&
               (!stride_eff || (beat_x[0] == K_M1[0] && beat_y[0] == K_M1[0]));
        last_win = emit && (beat_x == last_x) && (beat_y == last_y);

        if (sof_beat && !geom_ok_in) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
        end else if (process) begin
            state_d = RUN;
            if (end_of_line) begin
                x_d = '0;
                y_d = beat_y + 10'd1;
                if (beat_y == eff_yres - 10'd1) begin
                    state_d = IDLE;
                    y_d     = '0;
                end
            end else begin
                x_d = beat_x + 10'd1;
                y_d = beat_y;
            end
        end
    end

    // State, raster position and geometry latched at start of frame.
    always_ff @(posedge clock or posedge clock_areset) begin
        if (clock_areset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xres_q  <= '0;
            yres_q  <= '0;
`ifdef SLIDING_WINDOW_STRIDE2_EN
            stride_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (start) begin
                xres_q <= xres;
                yres_q <= yres;
`ifdef SLIDING_WINDOW_STRIDE2_EN
                stride_q <= stride2;
`endif
            end
        end
    end

    for (genvar g = 0; g < K - 1; g++) begin : g_line
        pixel_t wr_pix;
        if (g == 0) begin : g_first
            assign wr_pix = in_data;
        end else begin : g_rest
            assign wr_pix = lb_rd[g-1];
        end
        line_buffer #(
            .DEPTH      (MAX_XRES),
            .DATA_WIDTH (CHANNELS * WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_line (
            .clock   (clock),
            .wr_en   (process),
            .addr    (beat_x[ADDR_WIDTH-1:0]),
            .wr_data (wr_pix),
            .rd_data (lb_rd[g])
        );
    end

    // Incoming column, oldest line first, newest pixel at the bottom.
    always_comb begin
        col_d[K-1] = in_data;
        for (int r = 0; r < K - 1; r++) begin
            col_d[r] = lb_rd[K-2-r];
        end
    end

    // Shift the window one column left and insert the new column on the right.
    always_comb begin
        win_d = win_q;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int row = 0; row < K; row++) begin
                for (int col = 0; col < K - 1; col++) begin
                    win_d[c][row*K+col] = win_q[c][row*K+col+1];
                end
                win_d[c][row*K+K-1] = col_d[row][c];
            end
        end
    end

    // Window shift register and single-entry output register.
    always_ff @(posedge clock or posedge clock_areset) begin
        if (clock_areset) begin
            win_q       <= '0;
            out_valid   <= 1'b0;
            window      <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_last    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= sof_beat && (state_q == RUN || !geom_ok_in);
            if (process) begin
                win_q <= win_d;
            end
            if (emit) begin
                out_valid <= 1'b1;
                window    <= win_d;
                out_x     <= beat_x - K_M1;
                out_y     <= beat_y - K_M1;
                out_last  <= last_win;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_stream.sv
// Bench for sliding_window_stream: frame-level reference model builds expected
// windows from stored 2-D frames; randomized data, gaps and backpressure.
module tb_sliding_window_stream;

    localparam int K    = 3;
    localparam int CH   = 2;
    localparam int W    = 16;
    localparam int MAXX = 16;

    typedef logic [CH-1:0][W-1:0]          pixel_t;
    typedef logic [CH-1:0][K*K-1:0][W-1:0] window_t;
    typedef struct {
        logic       sof;
        pixel_t     data;
        logic [9:0] xr;
        logic [9:0] yr;
        logic       st;
    } beat_t;
    typedef struct {
        window_t    win;
        logic [9:0] x;
        logic [9:0] y;
        logic       last;
    } win_t;

    logic       clock = 1'b0;
    logic       clock_areset;
    logic [9:0] xres, yres;
    logic       stride2;
    logic       in_valid, in_ready, in_sof;
    pixel_t     in_data;
    logic       out_valid, out_ready;
    window_t    window;
    logic [9:0] out_x, out_y;
    logic       out_last, frame_error;

    int checks = 0;
    int errors = 0;

    beat_t  beats[$];
    win_t   obs[$];
    win_t   exp_q[$];
    int     exp_err;
    pixel_t fp [64][64];

    int rs_err_pulses, rs_hold_bad, rs_rdy_bad, rs_timeout, rs_stall_low;

    sliding_window_stream #(
        .K(K), .CHANNELS(CH), .WIDTH(W), .MAX_XRES(MAXX)
    ) dut (
        .clock        (clock),
        .clock_areset (clock_areset),
        .xres         (xres),
        .yres         (yres),
`ifdef SLIDING_WINDOW_STRIDE2_EN
        .stride2      (stride2),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .window       (window),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_last     (out_last),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    task automatic start_stream();
        beats.delete();
        obs.delete();
    endtask

    // npix < 0 sends the whole frame; pattern=1 uses y*16+x on channel 0.
    task automatic add_frame(input int xr, input int yr, input int st, input int npix, input bit pattern);
        int total;
        total = (npix < 0) ? xr * yr : npix;
        for (int i = 0; i < total; i++) begin
            beat_t b;
            int px, py;
            px = (xr > 0) ? i % xr : 0;
            py = (xr > 0) ? i / xr : 0;
            b.sof = (i == 0);
            b.xr  = (i == 0) ? 10'(xr) : 10'($urandom_range(0, 1023));
            b.yr  = (i == 0) ? 10'(yr) : 10'($urandom_range(0, 1023));
            b.st  = (i == 0) ? st[0] : 1'($urandom_range(0, 1));
            if (pattern) begin
                b.data[0] = 16'(py * 16 + px);
                b.data[1] = 16'(16'hF000 + py * 16 + px);
            end else begin
                b.data[0] = 16'($urandom);
                b.data[1] = 16'($urandom);
            end
            beats.push_back(b);
        end
    endtask

    task automatic add_junk(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.sof = 1'b0;
            b.xr = 10'($urandom_range(0, 1023));
            b.yr = 10'($urandom_range(0, 1023));
            b.st = 1'b0;
            b.data[0] = 16'($urandom);
            b.data[1] = 16'($urandom);
            beats.push_back(b);
        end
    endtask

    // Reference: replay beats into a 2-D frame and cut every eligible window from it.
    task automatic build_expected();
        bit in_frame;
        bit take;
        bit gs;
        int px, py, gx, gy, ox, oy, lox, loy;
        in_frame = 0; gs = 0; px = 0; py = 0; gx = 0; gy = 0;
        exp_q.delete();
        exp_err = 0;
        foreach (beats[i]) begin
            take = in_frame;
            if (beats[i].sof) begin
                bit ok;
                ok = int'(beats[i].xr) >= K && int'(beats[i].xr) <= MAXX && int'(beats[i].yr) >= K;
                if (in_frame || !ok) exp_err++;
                in_frame = ok;
                take = ok;
                if (ok) begin
                    gx = int'(beats[i].xr);
                    gy = int'(beats[i].yr);
                    px = 0;
                    py = 0;
`ifdef SLIDING_WINDOW_STRIDE2_EN
                    gs = beats[i].st;
`else
                    gs = 0;
`endif
                end
            end
            if (take) begin
                fp[py][px] = beats[i].data;
                ox = px - (K - 1);
                oy = py - (K - 1);
                lox = gs ? ((gx - K) / 2) * 2 : gx - K;
                loy = gs ? ((gy - K) / 2) * 2 : gy - K;
                if (ox >= 0 && oy >= 0 && (!gs || (ox % 2 == 0 && oy % 2 == 0))) begin
                    win_t w;
                    for (int c = 0; c < CH; c++)
                        for (int r = 0; r < K; r++)
                            for (int cl = 0; cl < K; cl++)
                                w.win[c][cl + r * K] = fp[oy + r][ox + cl][c];
                    w.x = 10'(ox);
                    w.y = 10'(oy);
                    w.last = (ox == lox && oy == loy);
                    exp_q.push_back(w);
                end
                px++;
                if (px == gx) begin
                    px = 0;
                    py++;
                    if (py == gy) in_frame = 0;
                end
            end
        end
    endtask

    // mode 0: ready always; 1: random ready and gaps; 2: 5-cycle stall on first window; 3: never ready.
    task automatic run_stream(input int mode);
        int idx, cyc, drain, stall_left;
        bit prev_hold;
        win_t prev;
        logic prev_valid;
        idx = 0; cyc = 0; drain = 8; stall_left = -1; prev_hold = 0; prev_valid = 0;
        prev.win = '0; prev.x = '0; prev.y = '0; prev.last = 1'b0;
        rs_err_pulses = 0; rs_hold_bad = 0; rs_rdy_bad = 0; rs_timeout = 0; rs_stall_low = 0;
        while ((idx < beats.size() || drain > 0) && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (frame_error) rs_err_pulses++;
            if (prev_hold && (out_valid !== prev_valid || window !== prev.win ||
                              out_x !== prev.x || out_y !== prev.y || out_last !== prev.last))
                rs_hold_bad++;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && stall_left < 0) stall_left = 5;
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b0;
            endcase
            if (idx < beats.size()) begin
                in_valid = (mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
                in_sof   = beats[idx].sof;
                in_data  = beats[idx].data;
                xres     = beats[idx].xr;
                yres     = beats[idx].yr;
                stride2  = beats[idx].st;
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                drain--;
            end
            #1;
            if (in_ready !== (!out_valid || out_ready)) rs_rdy_bad++;
            if (mode == 2 && out_valid && !out_ready && in_ready === 1'b0) rs_stall_low++;
            if (out_valid && out_ready) begin
                win_t w;
                w.win = window; w.x = out_x; w.y = out_y; w.last = out_last;
                obs.push_back(w);
            end
            if (in_valid && in_ready) idx++;
            prev_hold  = out_valid && !out_ready;
            prev_valid = out_valid;
            prev.win = window; prev.x = out_x; prev.y = out_y; prev.last = out_last;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (cyc >= 5000) rs_timeout = 1;
    endtask

    function automatic int stream_diff();
        int n;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs[i].win !== exp_q[i].win || obs[i].x !== exp_q[i].x ||
                obs[i].y !== exp_q[i].y || obs[i].last !== exp_q[i].last)
                return i;
        return -1;
    endfunction

    task automatic test_reset();
        clock_areset = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        xres = '0; yres = '0; stride2 = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid=%b last=%b err=%b, expected 0 0 0", out_valid, out_last, frame_error);
        end
        checks++;
        if (out_x !== 10'd0 || out_y !== 10'd0 || window !== '0) begin
            errors++;
            $display("FAIL reset_data got x=%0d y=%0d win=%h, expected zeros", out_x, out_y, window);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b, expected 1", in_ready);
        end
        @(negedge clock);
        @(negedge clock);
        clock_areset = 1'b0;
    endtask

    task automatic test_basic();
        int fw [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        int ex [4] = '{0, 1, 0, 1};
        int ey [4] = '{0, 0, 1, 1};
        int d;
        start_stream();
        add_frame(4, 4, 0, -1, 1'b1);
        build_expected();
        run_stream(0);
        checks++;
        if (obs.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d windows, expected 4", obs.size());
        end
        if (obs.size() >= 4) begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (obs[0].win[0][i] !== 16'(fw[i])) begin
                    errors++;
                    $display("FAIL basic_first_win[%0d] got %0d, expected %0d", i, obs[0].win[0][i], fw[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs[i].x !== 10'(ex[i]) || obs[i].y !== 10'(ey[i]) || obs[i].last !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_pos[%0d] got (%0d,%0d) last=%b, expected (%0d,%0d) last=%b",
                             i, obs[i].x, obs[i].y, obs[i].last, ex[i], ey[i], i == 3);
                end
            end
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_stream idx %0d got win=%h, expected win=%h", d, obs[d].win, exp_q[d].win);
        end
        checks++;
        if (rs_err_pulses != 0 || rs_timeout != 0) begin
            errors++;
            $display("FAIL basic_errors got err=%0d timeout=%0d, expected 0 0", rs_err_pulses, rs_timeout);
        end
    endtask

    task automatic test_backpressure();
        int d;
        start_stream();
        add_frame(4, 4, 0, -1, 1'b1);
        build_expected();
        run_stream(2);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got %0d, expected %0d", obs.size(), exp_q.size());
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bp_stream idx %0d got (%0d,%0d), expected (%0d,%0d)", d, obs[d].x, obs[d].y, exp_q[d].x, exp_q[d].y);
        end
        checks++;
        if (rs_hold_bad != 0 || rs_rdy_bad != 0) begin
            errors++;
            $display("FAIL bp_hold got hold_bad=%0d ready_bad=%0d, expected 0 0", rs_hold_bad, rs_rdy_bad);
        end
        checks++;
        if (rs_stall_low != 5) begin
            errors++;
            $display("FAIL bp_in_ready_low got %0d cycles, expected 5", rs_stall_low);
        end
    endtask

    task automatic test_bad_geometry();
        int d;
        start_stream();
        add_frame(2, 4, 0, 4, 1'b0);
        add_frame(MAXX + 1, 4, 0, 4, 1'b0);
        add_frame(5, 4, 0, -1, 1'b0);
        build_expected();
        run_stream(1);
        checks++;
        if (rs_err_pulses != 2 || exp_err != 2) begin
            errors++;
            $display("FAIL badgeo_pulses got %0d, expected 2", rs_err_pulses);
        end
        checks++;
        if (obs.size() != 6) begin
            errors++;
            $display("FAIL badgeo_count got %0d, expected 6", obs.size());
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL badgeo_stream idx %0d got win=%h, expected win=%h", d, obs[d].win, exp_q[d].win);
        end
    endtask

    task automatic test_sof_abort();
        int d;
        start_stream();
        add_frame(6, 6, 0, 15, 1'b0);
        add_frame(6, 6, 0, -1, 1'b0);
        build_expected();
        run_stream(1);
        checks++;
        if (rs_err_pulses != 1) begin
            errors++;
            $display("FAIL abort_pulses got %0d, expected 1", rs_err_pulses);
        end
        checks++;
        if (obs.size() != 17) begin
            errors++;
            $display("FAIL abort_count got %0d, expected 17", obs.size());
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL abort_stream idx %0d got (%0d,%0d) win=%h, expected (%0d,%0d) win=%h",
                     d, obs[d].x, obs[d].y, obs[d].win, exp_q[d].x, exp_q[d].y, exp_q[d].win);
        end
    endtask

`ifdef SLIDING_WINDOW_STRIDE2_EN
    task automatic test_stride2();
        int ex [4] = '{0, 2, 0, 2};
        int ey [4] = '{0, 0, 2, 2};
        int d;
        start_stream();
        add_frame(6, 6, 1, -1, 1'b0);
        build_expected();
        run_stream(0);
        checks++;
        if (obs.size() != 4) begin
            errors++;
            $display("FAIL stride2_count got %0d, expected 4", obs.size());
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].x !== 10'(ex[i]) || obs[i].y !== 10'(ey[i]) || obs[i].last !== (i == 3)) begin
                errors++;
                $display("FAIL stride2_pos[%0d] got (%0d,%0d) last=%b, expected (%0d,%0d) last=%b",
                         i, obs[i].x, obs[i].y, obs[i].last, ex[i], ey[i], i == 3);
            end
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stride2_stream idx %0d got win=%h, expected win=%h", d, obs[d].win, exp_q[d].win);
        end
    endtask
`endif

    task automatic test_random();
        int d;
        for (int it = 0; it < 4; it++) begin
            start_stream();
            for (int f = 0; f < 3; f++) begin
                add_frame($urandom_range(K, MAXX), $urandom_range(K, 8), $urandom_range(0, 1), -1, 1'b0);
                add_junk($urandom_range(0, 2));
            end
            build_expected();
            run_stream(1);
            checks++;
            if (obs.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_count got %0d, expected %0d", it, obs.size(), exp_q.size());
            end
            d = stream_diff();
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL random%0d_stream idx %0d got (%0d,%0d) last=%b, expected (%0d,%0d) last=%b",
                         it, d, obs[d].x, obs[d].y, obs[d].last, exp_q[d].x, exp_q[d].y, exp_q[d].last);
            end
            checks++;
            if (rs_err_pulses != 0 || rs_hold_bad != 0 || rs_rdy_bad != 0 || rs_timeout != 0) begin
                errors++;
                $display("FAIL random%0d_flags got err=%0d hold=%0d rdy=%0d timeout=%0d, expected all 0",
                         it, rs_err_pulses, rs_hold_bad, rs_rdy_bad, rs_timeout);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int d;
        start_stream();
        add_frame(6, 6, 0, 15, 1'b0);
        run_stream(3);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pending got out_valid=%b, expected 1", out_valid);
        end
        #2;
        clock_areset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || window !== '0 || out_x !== 10'd0) begin
            errors++;
            $display("FAIL midreset_drop got valid=%b x=%0d, expected valid=0 x=0", out_valid, out_x);
        end
        @(negedge clock);
        clock_areset = 1'b0;
        start_stream();
        add_frame(6, 6, 0, -1, 1'b0);
        build_expected();
        run_stream(1);
        checks++;
        if (obs.size() != 16) begin
            errors++;
            $display("FAIL midreset_count got %0d, expected 16", obs.size());
        end
        d = stream_diff();
        checks++;
        if (d != -1 || rs_err_pulses != 0) begin
            errors++;
            $display("FAIL midreset_stream idx %0d err=%0d, expected idx -1 err 0", d, rs_err_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_geometry();
        test_sof_abort();
`ifdef SLIDING_WINDOW_STRIDE2_EN
        test_stride2();
`endif
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
